imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port and the data-memory (load/store) port of the RISC-V core.
- Arbitrates between the two requesters and sequences a one-outstanding-transaction memory handshake.
- Applies a timeout on the memory acknowledge and returns responses to the winning requester.
- Sits between the core (PC/fetch and load/store datapath) and the shared memory. The core stalls on the absence of a response.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DAT_WIDTH, 32, data width of all ports
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is pending before IF is forced to win (range 1..15)
- TIMEOUT_CYC, 64, cycles spent in REQ+WAIT without mem_ack_i before abort (range 2..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset (see interface rules)
- if_req_i  in  1  fetch request, level
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_ready_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid, 1-cycle pulse
- if_rdata_o  out  DAT_WIDTH  fetched instruction
- dm_req_i  in  1  data request, level
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DAT_WIDTH  store data
- dm_ready_o  out  1  data request accepted this cycle
- dm_done_o  out  1  load data valid / store complete, 1-cycle pulse
- dm_rdata_o  out  DAT_WIDTH  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DAT_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted mem_req_o
- mem_ack_i  in  1  read data valid / write done
- mem_rdata_i  in  DAT_WIDTH  memory read data
- err_o  out  1  timeout abort, pulses with the rvalid/done of the aborted transaction
- busy_o  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n is low:
  - state = IDLE.
  - All outputs are 0, including the rdata outputs.
  - Streak and timeout counters are 0.
  - Latched address, data and owner are 0.
- Reset asserted mid-transaction aborts the transaction silently: no rvalid, done or err pulse.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Arbitration is combinational.
  - When only one requester is asserted, it wins.
  - When both are asserted, DM wins unless streak == MAX_DM_STREAK, in which case IF wins.
  - The winner's ready_o is driven high combinationally in the same cycle.
  - On that clock edge: latch addr, we and wdata (IF: we = 0), record the owner, clear the timeout counter, and go to REQ.
  - No request: stay in IDLE.
- Streak counter:
  - Increments on a DM grant made while if_req_i is high, saturating at MAX_DM_STREAK.
  - Clears on any IF grant.
  - Holds otherwise.
- REQ:
  - mem_req_o = 1. mem_addr_o, mem_we_o and mem_wdata_o come from the latched values and are stable throughout REQ.
  - mem_gnt_i = 1 and mem_ack_i = 0: go to WAIT.
  - mem_gnt_i = 1 and mem_ack_i = 1 in the same cycle: go straight to RESP.
- WAIT:
  - mem_req_o = 0.
  - mem_ack_i = 1: go to RESP.
- Timeout:
  - The timeout counter increments every cycle in REQ and WAIT.
  - If the counter reaches TIMEOUT_CYC - 1 with no ack, go to RESP with the abort flag set.
  - An ack in that same cycle has priority over the timeout.
- Data capture: on ack, mem_rdata_i is registered into the owner's rdata_o. On abort, the owner's rdata_o is set to 0.
- RESP (exactly 1 cycle):
  - IF owner: if_rvalid_o = 1. DM owner: dm_done_o = 1.
  - err_o = abort flag.
  - Next state is IDLE.
  - No arbitration happens in RESP, so at least 1 IDLE cycle separates transactions.
- rdata hold: if_rdata_o and dm_rdata_o hold their last value until overwritten or reset. For DM stores, dm_rdata_o is unchanged.
- Minimum latency: request in cycle 0 (ready high), REQ with gnt+ack in cycle 1, rvalid/done in cycle 2.
- Requester rules:
  - Requesters hold req/addr/wdata stable until ready is seen.
  - A req dropped before ready has no effect.
  - A req dropped after ready does not cancel the transaction; the response is still delivered.
- Ignored inputs: mem_gnt_i and mem_ack_i are ignored in IDLE and RESP. mem_ack_i is ignored in REQ without mem_gnt_i.
- Invariant: if_ready_o and dm_ready_o are never high together.

Test Plan:
- Single fetch: if_req_i = 1, addr 0x10, mem gnt+ack in the first REQ cycle, rdata 0x00A00093 -> if_ready_o in cycle 0, if_rvalid_o in cycle 2 with if_rdata_o = 0x00A00093, err_o = 0.
- Store then load: DM store of 0xDEADBEEF to 0x100, then load from 0x100, memory ack delayed 3 cycles after gnt -> mem_we_o = 1 with wdata 0xDEADBEEF; dm_done_o pulses for both; the load returns 0xDEADBEEF.
- Contention fairness: MAX_DM_STREAK = 4, both requests held continuously -> grant order DM, DM, DM, DM, IF, DM, ...
- Timeout: TIMEOUT_CYC = 8, gnt given, ack never -> dm_done_o and err_o pulse together 8 cycles after REQ entry; dm_rdata_o = 0; state returns to IDLE.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately; after release no stray rvalid/done, and a new fetch completes normally.
- Gnt stall: mem_gnt_i held low 5 cycles in REQ -> mem_req_o stays high with constant addr; the request then completes normally provided the total time stays under TIMEOUT_CYC.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Grants one transaction at a time, limits DM streaks, and aborts on ack timeout.
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DAT_WIDTH     = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_ready_o,
    output logic                  if_rvalid_o,
    output logic [DAT_WIDTH-1:0]  if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DAT_WIDTH-1:0]  dm_wdata_i,
    output logic                  dm_ready_o,
    output logic                  dm_done_o,
    output logic [DAT_WIDTH-1:0]  dm_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DAT_WIDTH-1:0]  mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_ack_i,
    input  logic [DAT_WIDTH-1:0]  mem_rdata_i,
    output logic                  err_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT_CYC - 1);

    state_t                 state;
    logic [3:0]             streak;
    logic [7:0]             tcnt;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic                   lat_we;
    logic [DAT_WIDTH-1:0]   lat_wdata;
    logic                   owner_dm;

    logic grant_if, grant_dm, finish, timeout;

    // DM has priority except when it has starved a waiting fetch for too long.
    always_comb begin
        grant_dm = (state == IDLE) && dm_req_i && (!if_req_i || streak != STREAK_MAX);
        grant_if = (state == IDLE) && if_req_i && !grant_dm;
        finish   = ((state == REQ) && mem_gnt_i && mem_ack_i) || ((state == WAIT) && mem_ack_i);
        timeout  = ((state == REQ) || (state == WAIT)) && !finish && (tcnt == TCNT_LAST);
    end

    assign if_ready_o  = grant_if && rst_n;
    assign dm_ready_o  = grant_dm && rst_n;
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = (state == REQ) && lat_we;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;
    assign busy_o      = (state != IDLE);

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            streak      <= '0;
            tcnt        <= '0;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            owner_dm    <= 1'b0;
            if_rvalid_o <= 1'b0;
            dm_done_o   <= 1'b0;
            err_o       <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            dm_done_o   <= 1'b0;
            err_o       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_dm || grant_if) begin
                        lat_addr  <= grant_dm ? dm_addr_i : if_addr_i;
                        lat_we    <= grant_dm && dm_we_i;
                        lat_wdata <= grant_dm ? dm_wdata_i : '0;
                        owner_dm  <= grant_dm;
                        tcnt      <= '0;
                        state     <= REQ;
                    end
                    if (grant_if)
                        streak <= '0;
                    else if (grant_dm && if_req_i && streak != STREAK_MAX)
                        streak <= streak + 4'd1;
                end
                REQ, WAIT: begin
                    tcnt <= tcnt + 8'd1;
                    if (finish || timeout) begin
                        state       <= RESP;
                        if_rvalid_o <= !owner_dm;
                        dm_done_o   <= owner_dm;
                        err_o       <= timeout;
                        if (!owner_dm)
                            if_rdata_o <= timeout ? '0 : mem_rdata_i;
                        else if (timeout)
                            dm_rdata_o <= '0;
                        else if (!lat_we)
                            dm_rdata_o <= mem_rdata_i;
                    end else if (state == REQ && mem_gnt_i) begin
                        state <= WAIT;
                    end
                end
                RESP: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: fetch, store/load, fairness, timeout,
// reset during a transaction and grant stall.
module tb_imem_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ready_o, dm_done_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt = 1'b0, mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err_o, busy_o;

    int total = 0;
    int bad = 0;

    imem_dmem_arbiter #(
        .ADDR_WIDTH(AW), .DAT_WIDTH(DW), .MAX_DM_STREAK(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ready_o(dm_ready_o), .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic run_if(input logic [AW-1:0] addr, input logic [DW-1:0] rdata, input int stall);
        @(negedge clk); if_req = 1'b1; if_addr = addr; #1;
        total++;
        if (if_ready_o !== 1'b1 || dm_ready_o !== 1'b0) begin
            bad++; $display("FAIL if_ready: got if=%b dm=%b want if=1 dm=0", if_ready_o, dm_ready_o);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); if_req = 1'b0; mem_gnt = 1'b0; mem_ack = (i == 1); #1;
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== addr) begin
                bad++; $display("FAIL stall_req: got req=%b addr=%h want req=1 addr=%h", mem_req_o, mem_addr_o, addr);
            end
        end
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; mem_ack = 1'b1; mem_rdata = rdata; #1;
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== addr || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL if_memreq: got req=%b addr=%h we=%b want 1 %h 0", mem_req_o, mem_addr_o, mem_we_o, addr);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_ack = 1'b0; #1;
        total++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== rdata || err_o !== 1'b0 || dm_done_o !== 1'b0) begin
            bad++; $display("FAIL if_resp: got rvalid=%b rdata=%h err=%b done=%b want 1 %h 0 0",
                            if_rvalid_o, if_rdata_o, err_o, dm_done_o, rdata);
        end
        @(negedge clk); #1;
        total++;
        if (if_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL if_idle: got rvalid=%b busy=%b want 0 0", if_rvalid_o, busy_o);
        end
    endtask

    task automatic run_dm(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input logic [DW-1:0] exp_rdata, input int delay);
        @(negedge clk); dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; #1;
        total++;
        if (dm_ready_o !== 1'b1 || if_ready_o !== 1'b0) begin
            bad++; $display("FAIL dm_ready: got dm=%b if=%b want dm=1 if=0", dm_ready_o, if_ready_o);
        end
        @(negedge clk); dm_req = 1'b0; mem_gnt = 1'b1; mem_ack = 1'b0; #1;
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== we || mem_addr_o !== addr || mem_wdata_o !== wdata) begin
            bad++; $display("FAIL dm_memreq: got req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                            mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, we, addr, wdata);
        end
        for (int i = 1; i < delay; i++) begin
            @(negedge clk); mem_gnt = 1'b0; #1;
            total++;
            if (mem_req_o !== 1'b0 || busy_o !== 1'b1 || dm_done_o !== 1'b0) begin
                bad++; $display("FAIL dm_wait: got req=%b busy=%b done=%b want 0 1 0", mem_req_o, busy_o, dm_done_o);
            end
        end
        @(negedge clk); mem_gnt = 1'b0; mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk); mem_ack = 1'b0; #1;
        total++;
        if (dm_done_o !== 1'b1 || err_o !== 1'b0 || dm_rdata_o !== exp_rdata || if_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL dm_resp: got done=%b err=%b rdata=%h rvalid=%b want 1 0 %h 0",
                            dm_done_o, err_o, dm_rdata_o, if_rvalid_o, exp_rdata);
        end
        @(negedge clk); #1;
        total++;
        if (dm_done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL dm_idle: got done=%b busy=%b want 0 0", dm_done_o, busy_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #12;
        total++;
        if (if_ready_o !== 1'b0 || dm_ready_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0 ||
            mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 || if_rvalid_o !== 1'b0 ||
            dm_done_o !== 1'b0 || err_o !== 1'b0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
            bad++; $display("FAIL reset_outputs: got rdy=%b%b busy=%b mreq=%b rv=%b done=%b err=%b ird=%h drd=%h want all 0",
                            if_ready_o, dm_ready_o, busy_o, mem_req_o, if_rvalid_o, dm_done_o, err_o, if_rdata_o, dm_rdata_o);
        end
        @(negedge clk); if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_single_fetch;
        run_if(32'h0000_0010, 32'h00A0_0093, 0);
    endtask

    task automatic test_store_load;
        run_dm(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 3);
        run_dm(1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);
    endtask

    task automatic test_contention;
        logic [6:0] order;
        order = 7'b1101111;
        for (int i = 0; i < 7; i++) begin
            logic seen, win_dm;
            int w;
            seen = 1'b0; win_dm = 1'b0; w = 0;
            while (!seen && w < 4) begin
                @(negedge clk); if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
                if_addr = 32'h0000_1000 + 32'(i); dm_addr = 32'h0000_2000 + 32'(i); #1;
                total++;
                if (if_ready_o === 1'b1 && dm_ready_o === 1'b1) begin
                    bad++; $display("FAIL both_ready: got if=1 dm=1 want at most one");
                end
                if (if_ready_o === 1'b1 || dm_ready_o === 1'b1) begin
                    seen = 1'b1; win_dm = dm_ready_o;
                end
                w++;
            end
            total++;
            if (!seen || win_dm !== order[i]) begin
                bad++; $display("FAIL grant_order[%0d]: got seen=%b dm=%b want dm=%b", i, seen, win_dm, order[i]);
            end
            @(negedge clk); mem_gnt = 1'b1; mem_ack = 1'b1; mem_rdata = 32'(i + 1);
            @(negedge clk); mem_gnt = 1'b0; mem_ack = 1'b0; #1;
            total++;
            if (dm_done_o !== win_dm || if_rvalid_o !== !win_dm) begin
                bad++; $display("FAIL grant_resp[%0d]: got done=%b rvalid=%b want %b %b", i, dm_done_o, if_rvalid_o, win_dm, !win_dm);
            end
        end
        @(negedge clk); if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_timeout;
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; #1;
        total++;
        if (dm_ready_o !== 1'b1) begin
            bad++; $display("FAIL to_ready: got %b want 1", dm_ready_o);
        end
        @(negedge clk); dm_req = 1'b0; mem_gnt = 1'b1; #1;
        total++;
        if (mem_req_o !== 1'b1) begin
            bad++; $display("FAIL to_req: got %b want 1", mem_req_o);
        end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk); mem_gnt = 1'b0; #1;
            total++;
            if (dm_done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b1) begin
                bad++; $display("FAIL to_early[%0d]: got done=%b err=%b busy=%b want 0 0 1", k, dm_done_o, err_o, busy_o);
            end
        end
        @(negedge clk); #1;
        total++;
        if (dm_done_o !== 1'b1 || err_o !== 1'b1 || dm_rdata_o !== '0) begin
            bad++; $display("FAIL to_abort: got done=%b err=%b rdata=%h want 1 1 0", dm_done_o, err_o, dm_rdata_o);
        end
        @(negedge clk); #1;
        total++;
        if (dm_done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL to_idle: got done=%b err=%b busy=%b want 0 0 0", dm_done_o, err_o, busy_o);
        end
    endtask

    task automatic test_gnt_stall;
        run_if(32'h0000_0080, 32'h0000_0013, 5);
    endtask

    task automatic test_reset_mid;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; mem_ack = 1'b0;
        @(negedge clk); mem_gnt = 1'b0; #1;
        total++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL mid_wait: got busy=%b req=%b want 1 0", busy_o, mem_req_o);
        end
        rst_n = 1'b0; dm_req = 1'b1; #1;
        total++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== '0 || if_rdata_o !== '0 ||
            dm_rdata_o !== '0 || if_rvalid_o !== 1'b0 || dm_done_o !== 1'b0 || err_o !== 1'b0 ||
            dm_ready_o !== 1'b0 || if_ready_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got busy=%b req=%b addr=%h ird=%h drd=%h rv=%b done=%b err=%b rdy=%b%b want all 0",
                            busy_o, mem_req_o, mem_addr_o, if_rdata_o, dm_rdata_o, if_rvalid_o, dm_done_o, err_o, if_ready_o, dm_ready_o);
        end
        @(negedge clk); dm_req = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); mem_ack = (k == 0); mem_gnt = (k == 0); #1;
            total++;
            if (if_rvalid_o !== 1'b0 || dm_done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++; $display("FAIL mid_stray[%0d]: got rv=%b done=%b err=%b busy=%b want 0 0 0 0", k, if_rvalid_o, dm_done_o, err_o, busy_o);
            end
        end
        mem_ack = 1'b0; mem_gnt = 1'b0;
        run_if(32'h0000_0044, 32'h0010_0073, 0);
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_store_load;
        test_contention;
        test_timeout;
        test_gnt_stall;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
